// File: rtl/memory_access_arbiter.sv
// Two-port arbiter and strobe sequencer in front of the single-port pattern memory.
// Define MEM_ARB_FIXED_PRIO_EN for fixed port-0 priority; round-robin otherwise.
module memory_access_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [1:0]             rq_valid,
    input  logic [1:0]             rq_write,
    input  logic [1:0][ADDR_W-1:0] rq_addr,
    input  logic [1:0][DATA_W-1:0] rq_wdata,
    output logic [1:0]             rq_ready,
    output logic [1:0]             rsp_valid,
    output logic [1:0][DATA_W-1:0] rsp_rdata,
    output logic                   busy,
    output logic                   mem_enable_n,
    output logic                   mem_write_n,
    output logic                   mem_read_n,
    output logic [ADDR_W-1:0]      mem_address,
    output logic [DATA_W-1:0]      mem_data_out,
    input  logic [DATA_W-1:0]      mem_data_in
);

    typedef enum logic [2:0] {IDLE, WSTB, WGAP, RSTB, RWAIT, RESP} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(RD_LAT - 1);

    state_t     state, state_nxt;
    logic [3:0] wait_cnt;
    logic       owner;
    logic       last_grant;
    logic       grant;
    logic       accept;

    // NOTE: every always_comb output gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        grant = 1'b0;
        case (rq_valid)
            2'b10:   grant = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
            2'b11:   grant = 1'b0;
`else
            2'b11:   grant = ~last_grant;
`endif
            default: grant = 1'b0;
        endcase
    end

    assign accept   = (state == IDLE) && (rq_valid != 2'b00);
    assign rq_ready = accept ? (2'b01 << grant) : 2'b00;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = rq_write[grant] ? WSTB : RSTB;
            WSTB:    state_nxt = WGAP;
            WGAP:    state_nxt = IDLE;
            RSTB:    state_nxt = RWAIT;
            RWAIT:   if (wait_cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            wait_cnt     <= 4'd0;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            mem_address  <= '0;
            mem_data_out <= '0;
            mem_enable_n <= 1'b1;
            mem_write_n  <= 1'b1;
            mem_read_n   <= 1'b1;
            rsp_valid    <= 2'b00;
            rsp_rdata    <= '0;
        end else begin
            state <= state_nxt;
            // Strobes are registered from the next state so the memory sees glitch-free edges.
            mem_enable_n <= !((state_nxt == WSTB) || (state_nxt == RSTB));
            mem_write_n  <= (state_nxt != WSTB);
            mem_read_n   <= (state_nxt != RSTB);
            rsp_valid    <= 2'b00;

            if (accept) begin
                mem_address  <= rq_addr[grant];
                mem_data_out <= rq_wdata[grant];
                owner        <= grant;
                last_grant   <= grant;
            end

            if (state == RSTB) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == RWAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            // Last RWAIT cycle: read data is valid now, present it during RESP.
            if ((state == RWAIT) && (wait_cnt == 4'd0)) begin
                rsp_rdata[owner] <= mem_data_in;
                rsp_valid[owner] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Bench for memory_access_arbiter: a transaction-level reference model checks instance 0 every cycle,
// directed vectors pin literal values, and two extra instances cover RD_LAT = 1 and 15.
module tb_memory_access_arbiter;

    localparam int N     = 3;
    localparam int LAT [N] = '{2, 1, 15};
    localparam int L0    = 2;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [1:0]       rq_valid  [N];
    logic [1:0]       rq_write  [N];
    logic [1:0][7:0]  rq_addr   [N];
    logic [1:0][15:0] rq_wdata  [N];
    logic [1:0]       rq_ready  [N];
    logic [1:0]       rsp_valid [N];
    logic [1:0][15:0] rsp_rdata [N];
    logic             busy      [N];
    logic             en_n      [N];
    logic             wr_n      [N];
    logic             rd_n      [N];
    logic [7:0]       maddr     [N];
    logic [15:0]      mdo       [N];
    logic [15:0]      mdi       [N];

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return {a, ~a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_inst
        memory_access_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(LAT[g])) u_dut (
            .clock        (clock),
            .reset_n      (reset_n),
            .rq_valid     (rq_valid[g]),
            .rq_write     (rq_write[g]),
            .rq_addr      (rq_addr[g]),
            .rq_wdata     (rq_wdata[g]),
            .rq_ready     (rq_ready[g]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_rdata    (rsp_rdata[g]),
            .busy         (busy[g]),
            .mem_enable_n (en_n[g]),
            .mem_write_n  (wr_n[g]),
            .mem_read_n   (rd_n[g]),
            .mem_address  (maddr[g]),
            .mem_data_out (mdo[g]),
            .mem_data_in  (mdi[g])
        );

        // Memory macro model: data valid only in the cycle exactly LAT after the read strobe.
        logic [15:0] mem [256];
        bit [255:0]  written;
        logic [15:0] held = 16'h0;
        int          age = 0;
        always @(posedge clock) begin
            if (!en_n[g] && !wr_n[g]) begin
                mem[maddr[g]]     <= mdo[g];
                written[maddr[g]] <= 1'b1;
            end
            if (!en_n[g] && !rd_n[g]) begin
                held <= written[maddr[g]] ? mem[maddr[g]] : init_val(maddr[g]);
                age  <= 1;
            end else if (age != 0 && age < 64) begin
                age <= age + 1;
            end
        end
        assign mdi[g] = (age == LAT[g]) ? held : 16'h0BAD;
    end

    // Strobe exclusivity on every instance, every cycle.
    always @(negedge clock) begin
        for (int g = 0; g < N; g++)
            check($sformatf("strobe_excl%0d", g), {31'd0, (!wr_n[g] && !rd_n[g])}, 32'd0);
    end

    // Transaction-level reference model for instance 0: k counts cycles since acceptance.
    initial begin : ref_model
        int k;
        bit kw, kown, last, gnt, take;
        logic [7:0]       ka;
        logic [15:0]      kd;
        logic [15:0]      sb_mem [256];
        logic [1:0][15:0] exp_rdata;
        logic [1:0]       exp_ready, exp_rv;
        for (int a = 0; a < 256; a++) sb_mem[a] = init_val(8'(a));
        k = 0; kw = 1'b0; kown = 1'b0; last = 1'b1; ka = '0; kd = '0; exp_rdata = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                k = 0; last = 1'b1; exp_rdata = '0;
                check("rst_busy", {31'd0, busy[0]}, 32'd0);
                check("rst_en_n", {31'd0, en_n[0]}, 32'd1);
                check("rst_wr_n", {31'd0, wr_n[0]}, 32'd1);
                check("rst_rd_n", {31'd0, rd_n[0]}, 32'd1);
                check("rst_rsp_valid", {30'd0, rsp_valid[0]}, 32'd0);
                check("rst_rdata", rsp_rdata[0], 32'd0);
                check("rst_addr", {24'd0, maddr[0]}, 32'd0);
                check("rst_wdata", {16'd0, mdo[0]}, 32'd0);
            end else begin
                take = (k == 0) && (rq_valid[0] != 2'b00);
                if (rq_valid[0] == 2'b11) gnt = FIXED ? 1'b0 : !last;
                else                      gnt = rq_valid[0][1];
                exp_ready = take ? (gnt ? 2'b10 : 2'b01) : 2'b00;
                exp_rv = 2'b00;
                if (!kw && k == L0 + 2) begin
                    exp_rv[kown]    = 1'b1;
                    exp_rdata[kown] = sb_mem[ka];
                end
                check("m_ready", {30'd0, rq_ready[0]}, {30'd0, exp_ready});
                check("m_busy", {31'd0, busy[0]}, {31'd0, (k != 0)});
                check("m_en_n", {31'd0, en_n[0]}, {31'd0, (k != 1)});
                check("m_wr_n", {31'd0, wr_n[0]}, {31'd0, !(k == 1 && kw)});
                check("m_rd_n", {31'd0, rd_n[0]}, {31'd0, !(k == 1 && !kw)});
                check("m_rsp_valid", {30'd0, rsp_valid[0]}, {30'd0, exp_rv});
                check("m_rdata", rsp_rdata[0], exp_rdata);
                if (k == 1) begin
                    check("m_addr", {24'd0, maddr[0]}, {24'd0, ka});
                    if (kw) check("m_wdata", {16'd0, mdo[0]}, {16'd0, kd});
                end
                if (take) begin
                    k = 1; kown = gnt; last = gnt;
                    kw = rq_write[0][gnt]; ka = rq_addr[0][gnt]; kd = rq_wdata[0][gnt];
                    if (kw) sb_mem[ka] = kd;
                end else if (k != 0) begin
                    k++;
                    if ((kw && k == 3) || (!kw && k == L0 + 3)) k = 0;
                end
            end
        end
    end

    task automatic do_req(input int g, input int p, input bit w, input logic [7:0] a,
                          input logic [15:0] d, output int t);
        @(posedge clock); #1;
        rq_valid[g][p] = 1'b1; rq_write[g][p] = w; rq_addr[g][p] = a; rq_wdata[g][p] = d;
        t = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (rq_ready[g][p]) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("req_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
        rq_valid[g][p] = 1'b0;
    endtask

    task automatic at_cycle(input int c);
        do @(negedge clock); while (cyc < c);
    endtask

    initial begin : stim
        int t, seen;
        int gq[$];
        for (int g = 0; g < N; g++) begin
            rq_valid[g] = '0; rq_write[g] = '0; rq_addr[g] = '0; rq_wdata[g] = '0;
        end
        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", {31'd0, busy[0]}, 32'd0);
        check("reset_ready", {30'd0, rq_ready[0]}, 32'd0);
        reset_n = 1'b1;

        // Write port 0
        do_req(0, 0, 1'b1, 8'h12, 16'hBEEF, t);
        at_cycle(t + 1);
        check("w_en_n", {31'd0, en_n[0]}, 32'd0);
        check("w_wr_n", {31'd0, wr_n[0]}, 32'd0);
        check("w_addr", {24'd0, maddr[0]}, 32'h12);
        check("w_data", {16'd0, mdo[0]}, 32'hBEEF);
        at_cycle(t + 2);
        check("w_gap_en_n", {31'd0, en_n[0]}, 32'd1);
        check("w_gap_busy", {31'd0, busy[0]}, 32'd1);
        at_cycle(t + 3);
        check("w_done_busy", {31'd0, busy[0]}, 32'd0);

        // Read port 1 returns the written data at T+4
        do_req(0, 1, 1'b0, 8'h12, 16'h0, t);
        at_cycle(t + 1);
        check("r_rd_n", {31'd0, rd_n[0]}, 32'd0);
        at_cycle(t + 2);
        check("r_rd_n_gap", {31'd0, rd_n[0]}, 32'd1);
        at_cycle(t + 4);
        check("r_rsp_valid", {30'd0, rsp_valid[0]}, 32'b10);
        check("r_rdata1", {16'd0, rsp_rdata[0][1]}, 32'hBEEF);
        check("r_rdata0", {16'd0, rsp_rdata[0][0]}, 32'h0);
        at_cycle(t + 5);
        check("r_rsp_end", {30'd0, rsp_valid[0]}, 32'd0);

        // Both ports valid continuously after reset
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        rq_valid[0] = 2'b11; rq_write[0] = 2'b11;
        rq_addr[0][0] = 8'h30; rq_wdata[0][0] = 16'h1111;
        rq_addr[0][1] = 8'h31; rq_wdata[0][1] = 16'h2222;
        for (int i = 0; i < 40 && gq.size() < 4; i++) begin
            @(negedge clock);
            if (rq_ready[0][0]) gq.push_back(0);
            if (rq_ready[0][1]) gq.push_back(1);
        end
        @(posedge clock); #1;
        rq_valid[0] = 2'b00;
        for (int i = 0; i < 4; i++)
            check($sformatf("grant_seq%0d", i), (i < gq.size()) ? gq[i] : 32'd9,
                  FIXED ? 32'd0 : 32'(i % 2));
        repeat (4) @(posedge clock);

        // Reset during RWAIT aborts the read; next read completes
        do_req(0, 0, 1'b0, 8'h12, 16'h0, t);
        at_cycle(t + 2);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy[0]}, 32'd0);
        check("abort_en_n", {31'd0, en_n[0]}, 32'd1);
        check("abort_rd_n", {31'd0, rd_n[0]}, 32'd1);
        check("abort_rsp", {30'd0, rsp_valid[0]}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        do_req(0, 0, 1'b0, 8'h12, 16'h0, t);
        at_cycle(t + 4);
        check("post_abort_rsp", {30'd0, rsp_valid[0]}, 32'b01);
        check("post_abort_rdata", {16'd0, rsp_rdata[0][0]}, 32'hBEEF);

        // Write on port 1, then port 0 raises valid during the RESP of a port-1 read
        do_req(0, 1, 1'b1, 8'h31, 16'h2222, t);
        repeat (3) @(posedge clock);
        do_req(0, 1, 1'b0, 8'h31, 16'h0, t);
        at_cycle(t + 3);
        @(posedge clock); #1;
        rq_valid[0][0] = 1'b1; rq_write[0][0] = 1'b1; rq_addr[0][0] = 8'h40; rq_wdata[0][0] = 16'h4444;
        @(negedge clock);
        check("resp_ready0", {31'd0, rq_ready[0][0]}, 32'd0);
        check("resp_valid1", {30'd0, rsp_valid[0]}, 32'b10);
        check("resp_rdata1", {16'd0, rsp_rdata[0][1]}, 32'h2222);
        @(negedge clock);
        check("idle_ready0", {31'd0, rq_ready[0][0]}, 32'd1);
        @(posedge clock); #1;
        rq_valid[0][0] = 1'b0;
        repeat (3) @(posedge clock);
        do_req(0, 0, 1'b0, 8'h40, 16'h0, t);
        at_cycle(t + 4);
        check("raw_rdata", {16'd0, rsp_rdata[0][0]}, 32'h4444);

        // Latency sweep on the RD_LAT=1 and RD_LAT=15 instances
        for (int g = 1; g < N; g++) begin
            do_req(g, 0, 1'b0, 8'h5A, 16'h0, t);
            seen = -1;
            for (int i = 0; i < 30; i++) begin
                @(negedge clock);
                if (rsp_valid[g][0]) begin
                    seen = cyc;
                    break;
                end
            end
            check($sformatf("lat_inst%0d", g), 32'(seen - t), (g == 1) ? 32'd3 : 32'd17);
            check($sformatf("lat_rdata%0d", g), {16'd0, rsp_rdata[g][0]}, 32'h5AA5);
            check($sformatf("lat_other%0d", g), {16'd0, rsp_rdata[g][1]}, 32'h0);
        end

        repeat (5) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
